pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/pc_sequencer_if.sv | 45 ++++
 rtl/pc_next_mux.sv | 25 ++
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the PC sequencer: sequencer states, next-PC selects,
// default vector addresses and the PC width.
package cpu_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] RESET_VEC_ADDR_DEFAULT = 32'd0;
    localparam logic [PC_W-1:0] INT_VEC_ADDR_DEFAULT   = 32'd2;

    typedef enum logic [2:0] {
        VEC_LO,
        VEC_HI,
        RUN,
        INT_LO,
        INT_HI
    } seq_state_e;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_BRANCH,
        PC_VECTOR
    } pc_sel_e;

    // Branch targets are 16-bit two's complement word addresses.
    function automatic logic [PC_W-1:0] sext16(input logic [15:0] value);
        return {{(PC_W-16){value[15]}}, value};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bus between the PC sequencer, instruction memory and decode.
interface pc_sequencer_if;
    import cpu_pkg::*;

    logic            stall;
    logic            branch;
    logic [15:0]     branch_addr;
    logic            irq;
    logic [15:0]     imem_data;
    logic [PC_W-1:0] imem_addr;
    logic [PC_W-1:0] pc;
    logic            fetch_valid;
    logic            flush;
    logic            irq_ack;
    logic [PC_W-1:0] epc;

    modport master (
        input  stall,
        input  branch,
        input  branch_addr,
        input  irq,
        input  imem_data,
        output imem_addr,
        output pc,
        output fetch_valid,
        output flush,
        output irq_ack,
        output epc
    );

    modport slave (
        output stall,
        output branch,
        output branch_addr,
        output irq,
        output imem_data,
        input  imem_addr,
        input  pc,
        input  fetch_valid,
        input  flush,
        input  irq_ack,
        input  epc
    );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: hold, increment, sign-extended branch
// target, or a vector assembled from two instruction-memory halves.
module pc_next_mux
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    input  logic [15:0]     branch_addr_i,
    input  logic [15:0]     vec_hi_i,
    input  logic [15:0]     vec_lo_i,
    input  pc_sel_e         sel_i,
    output logic [PC_W-1:0] next_pc_o
);

    always_comb begin
        next_pc_o = pc_i;
        unique case (sel_i)
            PC_HOLD:   next_pc_o = pc_i;
            PC_INC:    next_pc_o = pc_i + 32'd1;
            PC_BRANCH: next_pc_o = sext16(branch_addr_i);
            PC_VECTOR: next_pc_o = {vec_hi_i, vec_lo_i};
            default:   next_pc_o = pc_i;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches reset/interrupt vectors as two 16-bit
// halves, then runs the PC with branch, interrupt and stall handling.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VEC_ADDR = RESET_VEC_ADDR_DEFAULT,
    parameter logic [PC_W-1:0] INT_VEC_ADDR   = INT_VEC_ADDR_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    pc_sequencer_if.master     bus
);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] epc_q;
    logic [15:0]     vec_lo_q;

    pc_sel_e         pc_sel;
    logic [PC_W-1:0] imem_addr_c;
    logic            fetch_valid_c;
    logic            flush_c;
    logic            irq_ack_c;

    pc_next_mux u_pc_next_mux (
        .pc_i          (pc_q),
        .branch_addr_i (bus.branch_addr),
        .vec_hi_i      (bus.imem_data),
        .vec_lo_i      (vec_lo_q),
        .sel_i         (pc_sel),
        .next_pc_o     (pc_d)
    );

    // Branch outranks irq, so an irq coincident with a branch is taken on
    // the following RUN cycle and saves the branch target as epc.
    always_comb begin
        state_d       = state_q;
        pc_sel        = PC_HOLD;
        imem_addr_c   = pc_q;
        fetch_valid_c = 1'b0;
        flush_c       = 1'b0;
        irq_ack_c     = 1'b0;
        unique case (state_q)
            VEC_LO: begin
                imem_addr_c = RESET_VEC_ADDR;
                state_d     = VEC_HI;
            end
            VEC_HI: begin
                imem_addr_c = RESET_VEC_ADDR + 32'd1;
                pc_sel      = PC_VECTOR;
                state_d     = RUN;
            end
            INT_LO: begin
                imem_addr_c = INT_VEC_ADDR;
                state_d     = INT_HI;
            end
            INT_HI: begin
                imem_addr_c = INT_VEC_ADDR + 32'd1;
                pc_sel      = PC_VECTOR;
                state_d     = RUN;
            end
            RUN: begin
                if (bus.branch) begin
                    pc_sel  = PC_BRANCH;
                    flush_c = 1'b1;
                end else if (bus.irq) begin
                    irq_ack_c = 1'b1;
                    flush_c   = 1'b1;
                    state_d   = INT_LO;
                end else if (!bus.stall) begin
                    pc_sel        = PC_INC;
                    fetch_valid_c = 1'b1;
                end
            end
            default: state_d = VEC_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= VEC_LO;
            pc_q     <= '0;
            epc_q    <= '0;
            vec_lo_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == VEC_LO || state_q == INT_LO) begin
                vec_lo_q <= bus.imem_data;
            end
            if (irq_ack_c) begin
                epc_q <= pc_q;
            end
        end
    end

    // Pulses are suppressed for the whole reset cycle, whatever state we are in.
    assign bus.imem_addr   = imem_addr_c;
    assign bus.pc          = pc_q;
    assign bus.epc         = epc_q;
    assign bus.fetch_valid = fetch_valid_c & ~reset;
    assign bus.flush       = flush_c & ~reset;
    assign bus.irq_ack     = irq_ack_c & ~reset;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expectations are queued per step and
// drained against the DUT outputs at the falling edge of the same cycle.
module tb_pc_sequencer;
    import cpu_pkg::*;

    typedef enum int {F_PC, F_EPC, F_ADDR, F_FV, F_FLUSH, F_ACK} fld_e;

    typedef struct {
        string       tag;
        fld_e        fld;
        logic [31:0] exp;
    } sb_entry_t;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] mem [0:255];
    sb_entry_t   sb [$];
    int checkCount = 0;
    int passCount  = 0;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_VEC_ADDR (32'd0),
        .INT_VEC_ADDR   (32'd2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_data = mem[bus.imem_addr[7:0]];

    task automatic applyStimulus(input logic rst, input logic st, input logic br,
                                 input logic [15:0] ba, input logic iq);
        @(posedge clk);
        #1;
        reset           = rst;
        bus.stall       = st;
        bus.branch      = br;
        bus.branch_addr = ba;
        bus.irq         = iq;
    endtask

    task automatic expectOut(input string tag, input fld_e fld, input logic [31:0] exp);
        sb.push_back('{tag, fld, exp});
    endtask

    task automatic checkOutput();
        sb_entry_t   e;
        logic [31:0] obs;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.fld)
                F_PC:    obs = bus.pc;
                F_EPC:   obs = bus.epc;
                F_ADDR:  obs = bus.imem_addr;
                F_FV:    obs = {31'd0, bus.fetch_valid};
                F_FLUSH: obs = {31'd0, bus.flush};
                default: obs = {31'd0, bus.irq_ack};
            endcase
            checkCount++;
            assert (obs === e.exp) passCount++;
            else $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before end of sequence");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0020;
        mem[1] = 16'h0000;
        mem[2] = 16'h0100;
        mem[3] = 16'h0000;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.branch = 1'b0;
        bus.branch_addr = 16'h0000;
        bus.irq = 1'b0;

        // Reset state
        applyStimulus(1, 0, 0, 16'h0000, 0);
        expectOut("rst_pc", F_PC, 32'h0);
        expectOut("rst_epc", F_EPC, 32'h0);
        expectOut("rst_fv", F_FV, 32'h0);
        expectOut("rst_flush", F_FLUSH, 32'h0);
        expectOut("rst_ack", F_ACK, 32'h0);
        expectOut("rst_addr", F_ADDR, 32'h0);
        checkOutput();

        // Reset vector fetch
        applyStimulus(0, 0, 0, 16'h0000, 0);
        expectOut("veclo_addr", F_ADDR, 32'h0);
        expectOut("veclo_fv", F_FV, 32'h0);
        checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0);
        expectOut("vechi_addr", F_ADDR, 32'h1);
        expectOut("vechi_fv", F_FV, 32'h0);
        checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0);
        expectOut("run_pc20", F_PC, 32'h20);
        expectOut("run_fv", F_FV, 32'h1);
        expectOut("run_addr", F_ADDR, 32'h20);
        checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0);
        expectOut("inc_pc21", F_PC, 32'h21);
        checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0);
        expectOut("inc_pc22", F_PC, 32'h22);
        checkOutput();

        // Branches, including a negative target
        applyStimulus(0, 0, 1, 16'h0030, 0);
        expectOut("br30_pc", F_PC, 32'h23);
        expectOut("br30_flush", F_FLUSH, 32'h1);
        expectOut("br30_fv", F_FV, 32'h0);
        checkOutput();
        applyStimulus(0, 1, 1, 16'hFFF0, 0);
        expectOut("brneg_pc", F_PC, 32'h30);
        expectOut("brneg_flush", F_FLUSH, 32'h1);
        checkOutput();
        applyStimulus(0, 0, 1, 16'h0040, 0);
        expectOut("sext_pc", F_PC, 32'hFFFF_FFF0);
        expectOut("sext_addr", F_ADDR, 32'hFFFF_FFF0);
        checkOutput();

        // Interrupt entry at pc 0x40
        applyStimulus(0, 0, 0, 16'h0000, 1);
        expectOut("irq_pc", F_PC, 32'h40);
        expectOut("irq_ack", F_ACK, 32'h1);
        expectOut("irq_flush", F_FLUSH, 32'h1);
        checkOutput();
        applyStimulus(0, 1, 1, 16'h1234, 1);
        expectOut("intlo_epc", F_EPC, 32'h40);
        expectOut("intlo_addr", F_ADDR, 32'h2);
        expectOut("intlo_ack", F_ACK, 32'h0);
        expectOut("intlo_flush", F_FLUSH, 32'h0);
        expectOut("intlo_fv", F_FV, 32'h0);
        checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0);
        expectOut("inthi_addr", F_ADDR, 32'h3);
        expectOut("inthi_pc", F_PC, 32'h40);
        checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0);
        expectOut("isr_pc", F_PC, 32'h100);
        expectOut("isr_fv", F_FV, 32'h1);
        checkOutput();

        // Stall for three cycles at 0x50
        applyStimulus(0, 0, 1, 16'h0050, 0);
        expectOut("br50_pc", F_PC, 32'h101);
        checkOutput();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 16'h0000, 0);
            expectOut("stall_pc", F_PC, 32'h50);
            expectOut("stall_fv", F_FV, 32'h0);
            checkOutput();
        end
        applyStimulus(0, 0, 0, 16'h0000, 0);
        expectOut("unstall_pc", F_PC, 32'h50);
        expectOut("unstall_fv", F_FV, 32'h1);
        checkOutput();
        applyStimulus(0, 0, 1, 16'h0070, 0);
        expectOut("post_stall_pc", F_PC, 32'h51);
        checkOutput();

        // Branch and irq together at 0x70
        applyStimulus(0, 0, 1, 16'h0060, 1);
        expectOut("brirq_pc", F_PC, 32'h70);
        expectOut("brirq_flush", F_FLUSH, 32'h1);
        expectOut("brirq_ack", F_ACK, 32'h0);
        checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 1);
        expectOut("lateirq_pc", F_PC, 32'h60);
        expectOut("lateirq_ack", F_ACK, 32'h1);
        checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0);
        expectOut("lateirq_epc", F_EPC, 32'h60);
        checkOutput();

        // Reset asserted during INT_HI
        applyStimulus(1, 0, 0, 16'h0000, 0);
        expectOut("rstint_fv", F_FV, 32'h0);
        expectOut("rstint_ack", F_ACK, 32'h0);
        expectOut("rstint_pc", F_PC, 32'h60);
        checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0);
        expectOut("rstint_vec_addr", F_ADDR, 32'h0);
        expectOut("rstint_vec_pc", F_PC, 32'h0);
        expectOut("rstint_vec_epc", F_EPC, 32'h0);
        checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0);
        applyStimulus(0, 0, 0, 16'h0000, 0);
        expectOut("rerun_pc", F_PC, 32'h20);
        checkOutput();

        // Wrap of the PC from 0xFFFFFFFF
        applyStimulus(0, 0, 1, 16'hFFFF, 0);
        expectOut("brff_pc", F_PC, 32'h21);
        checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0);
        expectOut("max_pc", F_PC, 32'hFFFF_FFFF);
        expectOut("max_fv", F_FV, 32'h1);
        checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0);
        expectOut("wrap_pc", F_PC, 32'h0);
        checkOutput();

        // Reset in RUN masks pulses that the inputs would otherwise produce
        applyStimulus(1, 0, 1, 16'h0010, 1);
        expectOut("rstrun_pc", F_PC, 32'h1);
        expectOut("rstrun_flush", F_FLUSH, 32'h0);
        expectOut("rstrun_ack", F_ACK, 32'h0);
        expectOut("rstrun_fv", F_FV, 32'h0);
        checkOutput();
        applyStimulus(0, 0, 0, 16'h0000, 0);
        expectOut("rstrun_after_pc", F_PC, 32'h0);
        expectOut("rstrun_after_addr", F_ADDR, 32'h0);
        checkOutput();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
